// File: rtl/depkt_pkg.sv
// ============================================================================
// Module      : depkt_pkg
// Description : Shared constants and state type for the header depacketizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package depkt_pkg;

    localparam int         HDR_BITS   = 432;
    localparam int         HDR_BYTES  = 54;
    localparam int         HDR_WORDS  = 14;
    localparam logic [1:0] LAST_EMPTY = 2'd2;

    typedef enum logic [1:0] {
        s_IDLE = 2'd0,
        s_BODY = 2'd1,
        s_DROP = 2'd2,
        s_DONE = 2'd3
    } depkt_state_t;

endpackage

`default_nettype wire

// File: rtl/depacketizer.sv
// ============================================================================
// Module      : depacketizer
// Description : Reassembles a 14-beat 32-bit RX frame into a 432-bit header,
//               pulsing done on commit and err on a dropped frame.
//               Optional error counter enabled by DEPKT_ERR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module depacketizer
    import depkt_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         eth_data,
    input  logic                eth_valid,
    output logic                eth_ready,
    input  logic                p_start,
    input  logic                p_end,
    input  logic [1:0]          empty,
    output logic [HDR_BITS-1:0] header,
    output logic                done,
    output logic                err
`ifdef DEPKT_ERR_CNT_EN
    ,
    output logic [15:0]         err_count
`endif
);

    localparam int         c_STAGE_WORDS = HDR_WORDS - 1;
    localparam logic [3:0] c_LAST_BATCH  = 4'(HDR_WORDS - 1);

    depkt_state_t                  r_state;
    logic [3:0]                    r_batch;
    logic                          r_done;
    logic                          r_err;
    logic [HDR_BITS-1:0]           r_header;
    logic [c_STAGE_WORDS*32-1:0]   w_stage;
    logic                          w_accept;
    logic                          w_store;
    logic [3:0]                    w_idx;

    assign eth_ready = !rst && (r_state != s_DONE);
    assign w_accept  = eth_valid && eth_ready;
    assign header    = r_header;
    assign done      = r_done;
    assign err       = r_err;

    // Which staging word (if any) the current beat lands in; a restart reuses word 0.
    always_comb begin
        w_store = 1'b0;
        w_idx   = r_batch;
        if (w_accept) begin
            case (r_state)
                s_IDLE: begin
                    if (p_start && !p_end) begin
                        w_store = 1'b1;
                        w_idx   = 4'd0;
                    end
                end
                s_BODY: begin
                    if (p_start) begin
                        w_store = 1'b1;
                        w_idx   = 4'd0;
                    end else if (!p_end && (r_batch < c_LAST_BATCH)) begin
                        w_store = 1'b1;
                    end
                end
                default: w_store = 1'b0;
            endcase
        end
    end

    for (genvar k = 0; k < c_STAGE_WORDS; k++) begin : g_stage
        logic [31:0] r_word;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_word <= '0;
            end else if (w_store && (w_idx == 4'(k))) begin
                r_word <= {eth_data[7:0], eth_data[15:8], eth_data[23:16], eth_data[31:24]};
            end
        end

        assign w_stage[32*k +: 32] = r_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= s_IDLE;
            r_batch  <= 4'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_header <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                s_IDLE: begin
                    if (w_accept) begin
                        if (p_start && !p_end) begin
                            r_state <= s_BODY;
                            r_batch <= 4'd1;
                        end else begin
                            r_err <= 1'b1;
                            if (!p_start && !p_end) begin
                                r_state <= s_DROP;
                            end
                        end
                    end
                end
                s_BODY: begin
                    if (w_accept) begin
                        if (p_start) begin
                            r_err   <= 1'b1;
                            r_batch <= 4'd1;
                        end else if (r_batch == c_LAST_BATCH) begin
                            r_batch <= 4'd0;
                            if (p_end && (empty == LAST_EMPTY)) begin
                                r_state  <= s_DONE;
                                r_done   <= 1'b1;
                                r_header <= {eth_data[23:16], eth_data[31:24], w_stage};
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= p_end ? s_IDLE : s_DROP;
                            end
                        end else if (p_end) begin
                            r_err   <= 1'b1;
                            r_state <= s_IDLE;
                            r_batch <= 4'd0;
                        end else begin
                            r_batch <= r_batch + 4'd1;
                        end
                    end
                end
                s_DROP: begin
                    if (w_accept && p_end) begin
                        r_state <= s_IDLE;
                    end
                end
                default: begin
                    r_state <= s_IDLE;
                    r_batch <= 4'd0;
                end
            endcase
        end
    end

`ifdef DEPKT_ERR_CNT_EN
    logic [15:0] r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= 16'd0;
        end else if (r_err && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

`default_nettype wire

// File: doc/depacketizer.md
# depacketizer

Receive-side counterpart of the header packetizer. The block accepts a 14-beat, 32-bit Avalon-ST style frame from the Ethernet RX path and reassembles it into a 432-bit (54-byte) header word. It presents the header to the TCP engine with a one-cycle `done` strobe, and drops malformed frames with an `err` strobe. It sits between the MAC RX stream and the header parser.

## Interface
- `HDR_BITS`, default 432: header width in bits. Fixed by the package; not overridable.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `eth_data` in 32: RX beat data.
- `eth_valid` in 1: beat valid.
- `eth_ready` out 1: block can accept a beat.
- `p_start` in 1: first beat of frame.
- `p_end` in 1: last beat of frame.
- `empty` in 2: count of unused low-order bytes on the `p_end` beat.
- `header` out 432: last good header, byte n at bits [8n+7:8n].
- `done` out 1: one-cycle pulse; `header` has just been updated.
- `err` out 1: one-cycle pulse; a frame was dropped.
- `err_count` out 16: present only when `DEPKT_ERR_CNT_EN` is defined.

## Operation
- A beat is accepted when `eth_valid && eth_ready`. Nothing changes on cycles with no accepted beat.
- `batch` is a 4-bit beat index. It is 0 in s_IDLE and increments on each accepted beat in s_BODY.
- Byte mapping for beat k (0..12):
  - staging byte 4k ← `eth_data[31:24]`
  - staging byte 4k+1 ← `[23:16]`
  - staging byte 4k+2 ← `[15:8]`
  - staging byte 4k+3 ← `[7:0]`
- Beat 13 supplies bytes 52 ← `[31:24]` and 53 ← `[23:16]`. Bits `[15:0]` of beat 13 are ignored.
- States:
  - **s_IDLE**
    - Beat with `p_start` and no `p_end` → store word 0, go to s_BODY with batch=1.
    - Beat with `p_start && p_end` → `err`, stay in s_IDLE.
    - Beat without `p_start` → `err`. Go to s_DROP, unless `p_end` is set, in which case stay in s_IDLE.
  - **s_BODY**
    - Beat with `p_start` → `err`. Restart with this beat as word 0 (batch=1).
    - Beat with `p_end` and batch<13 → `err`, go to s_IDLE (short frame).
    - Beat with batch==13, `p_end`=1 and `empty`==2 → commit, go to s_DONE.
    - Beat with batch==13, `p_end`=1 and `empty`≠2 → `err`, go to s_IDLE.
    - Beat with batch==13 and `p_end`=0 → `err`, go to s_DROP (long frame).
    - Otherwise store the beat and increment batch.
  - **s_DROP**: discard beats until a `p_end` beat, then go to s_IDLE. A `p_start` beat in s_DROP is also discarded.
  - **s_DONE**: `eth_ready`=0 for exactly one cycle, then go to s_IDLE.
- Commit copies staging bytes 0..51 plus the final two bytes into `header` on the same edge.
- `header` changes only on commit. A dropped frame never alters `header`.
- The staging register is not cleared between frames. Any bytes left over from a dropped frame are fully overwritten by the next good frame.

## Timing
- Reset values: state s_IDLE, batch 0, `header` 0, staging 0, `done` 0, `err` 0, `err_count` 0.
- `eth_ready` = !rst && state≠s_DONE. It is a combinational function of state.
- `done` = (state==s_DONE). It is high the cycle after the final beat is accepted, with `header` already valid in that cycle.
- `err` is registered and high the cycle after the offending beat.
- Minimum inter-frame gap is one cycle (s_DONE). Sustained throughput is 14 beats per 15 cycles.
- `rst` wins over any simultaneous beat. A reset mid-frame abandons the frame with no `err`, and `header` returns to 0.
- A frame restart (`p_start` in s_BODY) raises `err` and accepts the new beat in the same cycle.

## Configuration
- `DEPKT_ERR_CNT_EN` defined:
  - Adds the `err_count` port, a 16-bit counter that increments on every `err` pulse.
  - The counter saturates at 16'hFFFF and is cleared by `rst`.
- Not defined: no port, no counter logic. Error reporting is limited to the `err` pulse.

## Structure
- Package `depkt_pkg` holds:
  - `HDR_BITS`=432, `HDR_BYTES`=54, `HDR_WORDS`=14, `LAST_EMPTY`=2'd2
  - the enum `depkt_state_t {s_IDLE, s_BODY, s_DROP, s_DONE}`
- No sub-module. Byte placement is a generate loop indexed by batch, kept inside `depacketizer`.

## Test plan
- **Good frame.** 14 beats with `eth_valid` high continuously; word k = {4k, 4k+1, 4k+2, 4k+3} as bytes, last beat `empty`=2 → `done`=1 one cycle after beat 13; `header[7:0]`=8'h00, `header[431:424]`=8'h35; `eth_ready`=0 in that cycle.
- **Backpressure and gaps.** Same frame with `eth_valid` toggled 1/0 → identical `header`. `done` occurs exactly once. No beat is accepted during s_DONE.
- **Short frame.** `p_end` on beat 5 → `err`=1 next cycle, `done` stays 0, `header` keeps the previous value, state returns to s_IDLE.
- **Long frame.** No `p_end` at beat 13, `p_end` at beat 16 → one `err`. Beats 14..16 are discarded. The next good frame commits correctly.
- **Bad empty and restart.** Beat 13 with `empty`=0 → `err`, `header` unchanged. `p_start` at beat 7 followed by 14 good beats → one `err` and then `done`.
- **Reset mid-frame and counter.** `rst` asserted at beat 8 → `header`=0, no `err`. With `DEPKT_ERR_CNT_EN` defined, 3 bad frames give `err_count`=3.
